mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Multicycle control sequencer for the 16-bit RISC core.
- Owns the step counter `Cnt` and arbitrates the single shared memory port between instruction fetch (PC side) and data access (ALU address side); the data side is selected through `MEMresource`.
- Decodes `InsM`/`InsL` from the instruction register to choose each instruction's cycle path.
- Generates the register-file, PC, IR and output strobes, plus `Buff_PC`, the end-of-instruction marker.

Parameters:
- MEM_WAIT_MAX, 7, memory wait cycles tolerated before `mem_err` is raised and the sequencer halts.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- InsM  in  5  IR[15:11] major opcode
- InsL  in  2  IR[1:0] minor opcode
- mem_ready  in  1  memory has completed the current access
- resume  in  1  leave HALT (level, sampled)
- Cnt  out  3  current step, T0..T4
- MEMresource  out  1  0 = memory addressed by PC, 1 = addressed by ALU result
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (store)
- ir_we  out  1  load IR from memory data
- pc_we  out  1  PC update
- rf_we  out  1  register-file write
- flag_we  out  1  flag register update
- out_we  out  1  OutR output-latch strobe
- Buff_PC  out  1  last step of the current instruction
- halted  out  1  core stopped by HLT
- mem_err  out  1  sticky memory timeout error

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While `rst_n`=0: state = FETCH, `Cnt`=0, `run_q`=0, `mem_err`=0, wait counter = 0. Every output is 0.
- First clk edge after `rst_n` rises sets `run_q`=1; the first `mem_req` appears in that cycle. All outputs are decoded from the registered state and qualified by `run_q`.
- T0 FETCH: `mem_req`=1, `MEMresource`=0.
  - If `mem_ready`=0, hold T0 and increment the wait counter.
  - If `mem_ready`=1, pulse `ir_we` and `pc_we` (PC+1), then go to T1.
- T1 DECODE: no strobes; `InsM`/`InsL` are valid from here on. Go to T2.
- T2 EXEC, by instruction class:
  - Class A (ADD/ADC/SUB/SBB 00000, ADDI 00111, SUBI 01000, MOV 01011, LHI 00001, LLI 00010): compute, go to T3 WB.
    - T3 WB asserts `rf_we`. Flag-setting ops (00000, 00111, 01000) also assert `flag_we` in T3.
    - T3 asserts `Buff_PC`; next state is T0.
  - Class L (LDRri 00011, LDRrr 00100/InsL=00): T2 address calc, T3 MEM, T4 WB.
    - T3 MEM: `mem_req`=1, `MEMresource`=1; hold until `mem_ready`.
    - T4 WB: `rf_we`=1, `Buff_PC`=1.
  - Class S (STRri 00101, STRrr 00110/InsL=00): T2 address calc, T3 MEM.
    - T3 MEM: `mem_req`=1, `mem_we`=1, `MEMresource`=1; hold until `mem_ready`.
    - `Buff_PC`=1 on the `mem_ready` cycle.
  - CMP (00110/InsL=01): T2 `flag_we`=1, `Buff_PC`=1.
  - Bcc/BAL (11000, 11001), JMP 10000, JR 10011: T2 `pc_we`=1, `Buff_PC`=1. The branch condition is evaluated in the datapath.
  - JALrl 10001, JALrr 10010: T2 `pc_we`=1; T3 `rf_we`=1 (link write), `Buff_PC`=1.
  - OutR (11100/InsL=00): T2 `out_we`=1, `Buff_PC`=1.
  - HLT (11100/InsL=01): T2 `Buff_PC`=1; next state HALT.
  - Any other encoding: T2 `Buff_PC`=1, executes as a NOP.
- HALT: `halted`=1, `Cnt`=0, no strobes. When `resume`=1 is sampled, next state is T0.
- `Cnt` equals the step index and is held constant during memory waits. `Buff_PC` is asserted only on the final cycle, including the `mem_ready` cycle of a stalled access.
- Memory timeout: the wait counter resets on each new access. If it reaches MEM_WAIT_MAX with `mem_ready` still 0:
  - `mem_err` is set (sticky until reset);
  - the state goes to HALT and the access is abandoned, so `mem_req` drops the next cycle.
- Mid-access reset: all strobes drop immediately (asynchronously); no partial write is sequenced afterwards.
- `mem_ready` is ignored in states that do not assert `mem_req`.

Decomposition:
- Package `mc_pkg`:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - 5-bit opcode constants: OP_ALU, OP_LHI, OP_LLI, OP_LDRRI, OP_LDRRR, OP_STRRI, OP_STRRR_CMP, OP_ADDI, OP_SUBI, OP_MOV, OP_BCC, OP_BAL, OP_JMP, OP_JALRL, OP_JALRR, OP_JR, OP_SYS;
  - instruction class encoding.
- One sub-module, `mc_ins_class`: combinational decode of `InsM`/`InsL` to class, flag-setting flag and link flag.

Test Plan:
- Release reset, `mem_ready` tied 1, IR=ADD (`InsM`=00000, `InsL`=00) → `Cnt` 0,1,2,3,0. `ir_we` and `pc_we` at T0; `rf_we`, `flag_we` and `Buff_PC` at T3. All outputs are 0 during reset and `mem_req` first rises one cycle after reset release.
- LDRri (00011) with `mem_ready` low for 2 cycles in T3 → `Cnt` stays 3 for 3 cycles with `MEMresource`=1 and `mem_req`=1; T4 gives `rf_we`=`Buff_PC`=1. Instruction length is 7 cycles.
- STRrr (00110/00) vs CMP (00110/01) → STRrr: `mem_we`=1 at T3, 4 cycles. CMP: `flag_we`+`Buff_PC` at T2, 3 cycles, with no `mem_we` ever.
- JALrl (10001) → `pc_we` at T2, `rf_we`+`Buff_PC` at T3. JMP (10000) ends at T2; BNE (11000) ends at T2 with `pc_we`=1.
- OutR then HLT (11100/00, 11100/01) → `out_we` pulse at T2; after HLT, `halted`=1 and `Cnt`=0. `resume`=1 gives a FETCH on the next cycle.
- `mem_ready` stuck 0 in FETCH → after MEM_WAIT_MAX (7) wait cycles, `mem_err`=1 and `halted`=1. Asserting `rst_n`=0 clears both asynchronously.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and opcode constants for the multicycle control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [4:0] OP_ALU       = 5'b00000;
  localparam logic [4:0] OP_LHI       = 5'b00001;
  localparam logic [4:0] OP_LLI       = 5'b00010;
  localparam logic [4:0] OP_LDRRI     = 5'b00011;
  localparam logic [4:0] OP_LDRRR     = 5'b00100;
  localparam logic [4:0] OP_STRRI     = 5'b00101;
  localparam logic [4:0] OP_STRRR_CMP = 5'b00110;
  localparam logic [4:0] OP_ADDI      = 5'b00111;
  localparam logic [4:0] OP_SUBI      = 5'b01000;
  localparam logic [4:0] OP_MOV       = 5'b01011;
  localparam logic [4:0] OP_JMP       = 5'b10000;
  localparam logic [4:0] OP_JALRL     = 5'b10001;
  localparam logic [4:0] OP_JALRR     = 5'b10010;
  localparam logic [4:0] OP_JR        = 5'b10011;
  localparam logic [4:0] OP_BCC       = 5'b11000;
  localparam logic [4:0] OP_BAL       = 5'b11001;
  localparam logic [4:0] OP_SYS       = 5'b11100;

  localparam logic [2:0] STEP_T0 = 3'd0;
  localparam logic [2:0] STEP_T1 = 3'd1;
  localparam logic [2:0] STEP_T2 = 3'd2;
  localparam logic [2:0] STEP_T3 = 3'd3;
  localparam logic [2:0] STEP_T4 = 3'd4;

  typedef enum logic [3:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_CMP,
    CL_BR,
    CL_JAL,
    CL_OUT,
    CL_HLT,
    CL_NOP
  } cls_e;

  typedef struct packed {
    cls_e cls;
    logic sets_flag;
    logic link;
  } dec_t;

  function automatic logic is_access(state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/mc_ins_class.sv
// Combinational decode of the IR opcode fields into an execution class.
module mc_ins_class
  import mc_pkg::*;
(
  input  logic [4:0] ins_m_i,
  input  logic [1:0] ins_l_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o.cls       = CL_NOP;
    dec_o.sets_flag = 1'b0;
    dec_o.link      = 1'b0;
    case (ins_m_i)
      OP_ALU, OP_ADDI, OP_SUBI: begin
        dec_o.cls       = CL_ALU;
        dec_o.sets_flag = 1'b1;
      end
      OP_LHI, OP_LLI, OP_MOV: dec_o.cls = CL_ALU;
      OP_LDRRI:               dec_o.cls = CL_LOAD;
      OP_LDRRR: if (ins_l_i == 2'b00) dec_o.cls = CL_LOAD;
      OP_STRRI:               dec_o.cls = CL_STORE;
      OP_STRRR_CMP: begin
        if (ins_l_i == 2'b00)      dec_o.cls = CL_STORE;
        else if (ins_l_i == 2'b01) dec_o.cls = CL_CMP;
      end
      OP_BCC, OP_BAL, OP_JMP, OP_JR: dec_o.cls = CL_BR;
      OP_JALRL, OP_JALRR: begin
        dec_o.cls  = CL_JAL;
        dec_o.link = 1'b1;
      end
      OP_SYS: begin
        if (ins_l_i == 2'b00)      dec_o.cls = CL_OUT;
        else if (ins_l_i == 2'b01) dec_o.cls = CL_HLT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: step counter, shared memory port arbitration
// and per-step strobe generation for the 16-bit RISC core.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] InsM,
  input  logic [1:0] InsL,
  input  logic       mem_ready,
  input  logic       resume,
  output logic [2:0] Cnt,
  output logic       MEMresource,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic       flag_we,
  output logic       out_we,
  output logic       Buff_PC,
  output logic       halted,
  output logic       mem_err
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            err_q, err_d;
  logic            run_q;
  dec_t            dec;

  mc_ins_class u_cls (
    .ins_m_i (InsM),
    .ins_l_i (InsL),
    .dec_o   (dec)
  );

  // A stalled access either keeps counting or, on its last tolerated wait,
  // abandons the access and parks the core in HALT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wait_d  = '0;
    if (is_access(state_q) && !mem_ready) begin
      if (wait_q == WW'(MEM_WAIT_MAX - 1)) begin
        err_d   = 1'b1;
        state_d = ST_HALT;
        cnt_d   = STEP_T0;
      end else begin
        wait_d = wait_q + WW'(1);
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          state_d = ST_DECODE;
          cnt_d   = STEP_T1;
        end
        ST_DECODE: begin
          state_d = ST_EXEC;
          cnt_d   = STEP_T2;
        end
        ST_EXEC: begin
          if (dec.cls == CL_ALU || dec.link) begin
            state_d = ST_WB;
            cnt_d   = STEP_T3;
          end else if (dec.cls == CL_LOAD || dec.cls == CL_STORE) begin
            state_d = ST_MEM;
            cnt_d   = STEP_T3;
          end else if (dec.cls == CL_HLT) begin
            state_d = ST_HALT;
            cnt_d   = STEP_T0;
          end else begin
            state_d = ST_FETCH;
            cnt_d   = STEP_T0;
          end
        end
        ST_MEM: begin
          if (dec.cls == CL_LOAD) begin
            state_d = ST_WB;
            cnt_d   = STEP_T4;
          end else begin
            state_d = ST_FETCH;
            cnt_d   = STEP_T0;
          end
        end
        ST_WB: begin
          state_d = ST_FETCH;
          cnt_d   = STEP_T0;
        end
        ST_HALT: begin
          if (resume) begin
            state_d = ST_FETCH;
            cnt_d   = STEP_T0;
          end
        end
        default: begin
          state_d = ST_FETCH;
          cnt_d   = STEP_T0;
        end
      endcase
    end
  end

  // run_q holds the FSM in FETCH for one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cnt_q   <= STEP_T0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    Cnt         = '0;
    MEMresource = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    rf_we       = 1'b0;
    flag_we     = 1'b0;
    out_we      = 1'b0;
    Buff_PC     = 1'b0;
    halted      = 1'b0;
    mem_err     = run_q & err_q;
    if (run_q) begin
      Cnt = cnt_q;
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        ST_EXEC: begin
          case (dec.cls)
            CL_CMP: begin
              flag_we = 1'b1;
              Buff_PC = 1'b1;
            end
            CL_BR: begin
              pc_we   = 1'b1;
              Buff_PC = 1'b1;
            end
            CL_JAL: pc_we = 1'b1;
            CL_OUT: begin
              out_we  = 1'b1;
              Buff_PC = 1'b1;
            end
            CL_HLT, CL_NOP: Buff_PC = 1'b1;
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req     = 1'b1;
          MEMresource = 1'b1;
          mem_we      = (dec.cls == CL_STORE);
          Buff_PC     = (dec.cls == CL_STORE) && mem_ready;
        end
        ST_WB: begin
          rf_we   = 1'b1;
          flag_we = dec.sets_flag && (dec.cls == CL_ALU);
          Buff_PC = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized bench: per-instruction cycle scripts built from the ISA step rules.
module tb_mc_sequencer;

  logic       clk, rst_n;
  logic [4:0] InsM;
  logic [1:0] InsL;
  logic       mem_ready, resume;
  logic [2:0] Cnt;
  logic       MEMresource, mem_req, mem_we, ir_we, pc_we, rf_we;
  logic       flag_we, out_we, Buff_PC, halted, mem_err;

  mc_sequencer #(.MEM_WAIT_MAX(7)) dut (
    .clk(clk), .rst_n(rst_n), .InsM(InsM), .InsL(InsL),
    .mem_ready(mem_ready), .resume(resume), .Cnt(Cnt),
    .MEMresource(MEMresource), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .flag_we(flag_we),
    .out_we(out_we), .Buff_PC(Buff_PC), .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  logic [13:0] outv;
  assign outv = {Cnt, MEMresource, mem_req, mem_we, ir_we, pc_we, rf_we,
                 flag_we, out_we, Buff_PC, halted, mem_err};

  localparam logic [13:0] RES = 14'h400, REQ = 14'h200, WE  = 14'h100;
  localparam logic [13:0] IRW = 14'h080, PCW = 14'h040, RFW = 14'h020;
  localparam logic [13:0] FLW = 14'h010, OUW = 14'h008, BF  = 14'h004;
  localparam logic [13:0] HL  = 14'h002;

  typedef struct {
    logic [4:0]  m;
    logic [1:0]  l;
    bit          mr;
    bit          rs;
    logic [13:0] exp;
  } rec_t;

  rec_t q[$];
  bit   err;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(logic [4:0] m, logic [1:0] l, bit mr, bit rs, int cnt,
                      logic [13:0] s);
    rec_t r;
    r.m = m; r.l = l; r.mr = mr; r.rs = rs;
    r.exp = {cnt[2:0], 11'b0} | s | {13'b0, err};
    q.push_back(r);
  endtask

  // 0 alu, 1 flag-setting alu, 2 load, 3 store, 4 cmp, 5 branch, 6 jal,
  // 7 out, 8 hlt, 9 nop
  function automatic int kind(logic [4:0] m, logic [1:0] l);
    case (m)
      5'b00000, 5'b00111, 5'b01000: return 1;
      5'b00001, 5'b00010, 5'b01011: return 0;
      5'b00011:                     return 2;
      5'b00100:                     return (l == 2'b00) ? 2 : 9;
      5'b00101:                     return 3;
      5'b00110:                     return (l == 2'b00) ? 3 : (l == 2'b01) ? 4 : 9;
      5'b11000, 5'b11001, 5'b10000, 5'b10011: return 5;
      5'b10001, 5'b10010:           return 6;
      5'b11100:                     return (l == 2'b00) ? 7 : (l == 2'b01) ? 8 : 9;
      default:                      return 9;
    endcase
  endfunction

  task automatic halt_block(logic [4:0] m, logic [1:0] l);
    int n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) push(m, l, rnd(), (i == n - 1), 0, HL);
  endtask

  // f/d: wait cycles before the fetch / data access completes; 7 = timeout.
  task automatic plan(logic [4:0] m, logic [1:0] l, int f, int d);
    int k = kind(m, l);
    logic [13:0] s;
    for (int i = 0; i < f; i++) push(m, l, 0, rnd(), 0, REQ);
    if (f >= 7) begin err = 1; halt_block(m, l); return; end
    push(m, l, 1, rnd(), 0, REQ | IRW | PCW);
    push(m, l, rnd(), rnd(), 1, 14'h0);
    case (k)
      0, 1: begin
        push(m, l, rnd(), rnd(), 2, 14'h0);
        push(m, l, rnd(), rnd(), 3, RFW | BF | ((k == 1) ? FLW : 14'h0));
      end
      2, 3: begin
        push(m, l, rnd(), rnd(), 2, 14'h0);
        s = RES | REQ | ((k == 3) ? WE : 14'h0);
        for (int i = 0; i < d; i++) push(m, l, 0, rnd(), 3, s);
        if (d >= 7) begin err = 1; halt_block(m, l); return; end
        push(m, l, 1, rnd(), 3, s | ((k == 3) ? BF : 14'h0));
        if (k == 2) push(m, l, rnd(), rnd(), 4, RFW | BF);
      end
      4: push(m, l, rnd(), rnd(), 2, FLW | BF);
      5: push(m, l, rnd(), rnd(), 2, PCW | BF);
      6: begin
        push(m, l, rnd(), rnd(), 2, PCW);
        push(m, l, rnd(), rnd(), 3, RFW | BF);
      end
      7: push(m, l, rnd(), rnd(), 2, OUW | BF);
      8: begin
        push(m, l, rnd(), rnd(), 2, BF);
        halt_block(m, l);
      end
      default: push(m, l, rnd(), rnd(), 2, BF);
    endcase
  endtask

  task automatic play();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      InsM = r.m; InsL = r.l; mem_ready = r.mr; resume = r.rs;
      #2;
      chk($sformatf("op%b_%b", r.m, r.l), 32'(outv), 32'(r.exp));
    end
  endtask

  function automatic int pick_stall();
    int s = $urandom_range(0, 19);
    if (s < 16) return s % 4;
    if (s < 18) return 6;
    if (s == 18) return 5;
    return 7;
  endfunction

  logic [6:0] tbl [19] = '{7'b00000_00, 7'b00111_10, 7'b01000_01, 7'b01011_11,
                           7'b00001_00, 7'b00010_01, 7'b00011_10, 7'b00100_00,
                           7'b00101_11, 7'b00110_00, 7'b00110_01, 7'b11000_10,
                           7'b11001_00, 7'b10000_01, 7'b10011_11, 7'b10001_00,
                           7'b10010_10, 7'b11100_00, 7'b11100_01};

  initial begin
    logic [6:0] ins;
    clk = 0; rst_n = 0; InsM = 0; InsL = 0; mem_ready = 0; resume = 0; err = 0;
    repeat (2) @(negedge clk);
    mem_ready = 1; resume = 1;
    #2 chk("in_reset", 32'(outv), 32'h0);
    @(negedge clk);
    resume = 0;
    rst_n = 1;
    #2 chk("release", 32'(outv), 32'h0);

    plan(5'b00000, 2'b00, 0, 0);
    plan(5'b00011, 2'b00, 0, 2);
    plan(5'b00110, 2'b00, 0, 0);
    plan(5'b00110, 2'b01, 0, 0);
    plan(5'b10001, 2'b00, 0, 0);
    plan(5'b10000, 2'b00, 0, 0);
    plan(5'b11000, 2'b00, 0, 0);
    plan(5'b11100, 2'b00, 0, 0);
    plan(5'b11100, 2'b01, 0, 0);
    plan(5'b00100, 2'b00, 6, 6);
    plan(5'b00101, 2'b10, 2, 3);
    plan(5'b00100, 2'b01, 1, 0);
    play();

    for (int i = 0; i < 150; i++) begin
      ins = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 18)]
                                        : 7'($urandom_range(0, 127));
      plan(ins[6:2], ins[1:0], pick_stall(), pick_stall());
      play();
    end

    // Reset while a fetch is outstanding must drop the request at once.
    @(negedge clk);
    mem_ready = 0; resume = 0;
    #2 chk("pre_rst", 32'(outv), 32'(REQ | {13'b0, err}));
    #1 rst_n = 0;
    #1 chk("async_rst", 32'(outv), 32'h0);
    err = 0;
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 7; i++) push(5'b00000, 2'b00, 0, 0, 0, REQ);
    err = 1;
    push(5'b00000, 2'b00, 1, 0, 0, HL);
    play();
    #1 rst_n = 0;
    #1 chk("err_clr", 32'(outv), 32'h0);
    err = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
